// File: rtl/trig_auth_pkg.sv
`default_nettype none
// trig_auth_pkg: state encoding, parameter defaults and helpers shared by fire_authorizer_mc.
package trig_auth_pkg;

  localparam int DEF_NUM_CH          = 4;
  localparam int DEF_ENTROPY_W       = 8;
  localparam int DEF_ENTROPY_THRESH  = 100;
  localparam int DEF_SETTLE_CYCLES   = 4;
  localparam int DEF_COOLDOWN_CYCLES = 16;

  typedef enum logic [2:0] {
    ST_SETTLE   = 3'd0,
    ST_ARMED    = 3'd1,
    ST_FIRE     = 3'd2,
    ST_COOLDOWN = 3'd3,
    ST_LOCKED   = 3'd4,
    ST_ABORT    = 3'd5
  } fa_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// rr_arbiter: one-hot round-robin grant; the channel at ptr has highest priority.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int PTR_W  = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant
);

  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = PTR_W'((int'(ptr) + i) % NUM_CH);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fire_authorizer_mc.sv
`default_nettype none
// fire_authorizer_mc: risk-gated multi-channel fire authorizer with settle, round-robin
// grant, one-cycle fire pulse, cooldown and lock/abort handling.
module fire_authorizer_mc
  import trig_auth_pkg::*;
#(
  parameter int NUM_CH          = DEF_NUM_CH,
  parameter int ENTROPY_W       = DEF_ENTROPY_W,
  parameter int ENTROPY_THRESH  = DEF_ENTROPY_THRESH,
  parameter int SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
  parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    fire_req,
  input  logic [ENTROPY_W-1:0] entropy_score,
  input  logic                 analog_spike_detected,
  input  logic                 ml_risk_flag,
  input  logic                 manual_lock,
  output logic [NUM_CH-1:0]    enable_fire,
  output logic [2:0]           fsm_state,
  output logic [15:0]          abort_count
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int CDN_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;

  localparam logic [ENTROPY_W-1:0] THRESH      = ENTROPY_W'(ENTROPY_THRESH);
  localparam logic [SET_W-1:0]     SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [CDN_W-1:0]     CDN_LAST    = CDN_W'(COOLDOWN_CYCLES - 1);
  localparam logic [PTR_W-1:0]     PTR_LAST    = PTR_W'(NUM_CH - 1);

  fa_state_e          state;
  logic [SET_W-1:0]   settle_cnt;
  logic [CDN_W-1:0]   cool_cnt;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   next_ptr;
  logic [NUM_CH-1:0]  grant;
  logic               risk;

  assign risk      = analog_spike_detected | ml_risk_flag | (entropy_score >= THRESH);
  assign fsm_state = state;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .PTR_W  (PTR_W)
  ) u_rr_arbiter (
    .req   (fire_req),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) grant_idx = PTR_W'(i);
    end
  end

  assign next_ptr = (grant_idx == PTR_LAST) ? '0 : grant_idx + PTR_W'(1);

  // Lock and risk are checked ahead of the per-state logic, so they override any
  // grant, cooldown completion or settle completion in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_SETTLE;
      settle_cnt  <= '0;
      cool_cnt    <= '0;
      rr_ptr      <= '0;
      enable_fire <= '0;
      abort_count <= '0;
    end else begin
      enable_fire <= '0;
      if (manual_lock) begin
        state <= ST_LOCKED;
      end else if (risk) begin
        state <= ST_ABORT;
        if (state != ST_ABORT) abort_count <= sat_inc16(abort_count);
      end else begin
        case (state)
          ST_SETTLE: begin
            if (settle_cnt == SETTLE_LAST) state <= ST_ARMED;
            else                           settle_cnt <= settle_cnt + SET_W'(1);
          end
          ST_ARMED: begin
            if (|fire_req) begin
              state       <= ST_FIRE;
              enable_fire <= grant;
              rr_ptr      <= next_ptr;
            end
          end
          ST_FIRE: begin
            state    <= ST_COOLDOWN;
            cool_cnt <= '0;
          end
          ST_COOLDOWN: begin
            if (cool_cnt == CDN_LAST) state <= ST_ARMED;
            else                      cool_cnt <= cool_cnt + CDN_W'(1);
          end
          ST_LOCKED, ST_ABORT: begin
            state      <= ST_SETTLE;
            settle_cnt <= '0;
          end
          default: begin
            state       <= ST_ABORT;
            abort_count <= sat_inc16(abort_count);
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
